// File: rtl/fc_input_packer.sv
// Packs the flattened FC activation stream, one byte per handshake, into BRAM words.
// Byte 0 of each word lands in the MSB lane; load_done pulses once the whole frame is stored.
module fc_input_packer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned FRAME_SIZE = 288,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_run,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_data,
    output logic                  ce_output,
    output logic                  we_output,
    output logic [ADDR_WIDTH-1:0] addr_output,
    output logic [DATA_WIDTH-1:0] din_output,
    input  logic [DATA_WIDTH-1:0] qout_output,
    output logic                  busy,
    output logic                  load_done
);

    localparam int unsigned BPW    = DATA_WIDTH / 8;
    localparam int unsigned LANE_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int unsigned CNT_W  = $clog2(FRAME_SIZE + 1);

    typedef enum logic [1:0] {StIdle, StFill, StLast, StDone} state_e;

    state_e                state_q;
    logic [CNT_W-1:0]      byte_cnt_q;
    logic [LANE_W-1:0]     lane_cnt_q;
    logic [ADDR_WIDTH-1:0] word_cnt_q;
    logic [DATA_WIDTH-1:0] acc_q;

    logic [DATA_WIDTH-1:0] byte_word;
    logic                  accept;
    logic                  last_byte;
    logic                  last_lane;
    logic                  unused_qout;

    // Incoming byte placed in its lane: lane 0 is the MSB byte.
    assign byte_word = (DATA_WIDTH'(in_data) << (DATA_WIDTH - 8)) >> (8 * int'(lane_cnt_q));
    assign accept    = in_valid && in_ready;
    assign last_byte = (byte_cnt_q == CNT_W'(FRAME_SIZE - 1));
    assign last_lane = (lane_cnt_q == LANE_W'(BPW - 1));

    assign unused_qout = ^qout_output;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            in_ready    <= 1'b0;
            ce_output   <= 1'b0;
            we_output   <= 1'b0;
            addr_output <= '0;
            din_output  <= '0;
            busy        <= 1'b0;
            load_done   <= 1'b0;
            byte_cnt_q  <= '0;
            lane_cnt_q  <= '0;
            word_cnt_q  <= '0;
            acc_q       <= '0;
        end else begin
            ce_output  <= 1'b0;
            we_output  <= 1'b0;
            din_output <= '0;
            load_done  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (i_run) begin
                        state_q  <= StFill;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                StFill: begin
                    if (accept) begin
                        byte_cnt_q <= byte_cnt_q + CNT_W'(1);
                        if (last_lane || last_byte) begin
                            // Word complete: hand it to the output register, restart the accumulator.
                            ce_output   <= 1'b1;
                            we_output   <= 1'b1;
                            addr_output <= ADDR_WIDTH'(BASE_ADDR) + word_cnt_q;
                            din_output  <= acc_q | byte_word;
                            word_cnt_q  <= word_cnt_q + ADDR_WIDTH'(1);
                            acc_q       <= '0;
                            lane_cnt_q  <= '0;
                        end else begin
                            acc_q      <= acc_q | byte_word;
                            lane_cnt_q <= lane_cnt_q + LANE_W'(1);
                        end
                        if (last_byte) begin
                            state_q  <= StLast;
                            in_ready <= 1'b0;
                        end
                    end
                end
                StLast: begin
                    state_q   <= StDone;
                    load_done <= 1'b1;
                end
                StDone: begin
                    state_q    <= StIdle;
                    busy       <= 1'b0;
                    byte_cnt_q <= '0;
                    lane_cnt_q <= '0;
                    word_cnt_q <= '0;
                    acc_q      <= '0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_input_packer.sv
// Directed bench for fc_input_packer: four instances cover FRAME_SIZE 8, 6, 288 and BASE_ADDR 16.
module tb_fc_input_packer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic [3:0]  i_run_v;
    logic [3:0]  in_ready_v;
    logic [3:0]  ce_v;
    logic [3:0]  we_v;
    logic [3:0]  busy_v;
    logic [3:0]  done_v;
    logic [11:0] addr_v [4];
    logic [31:0] din_v [4];
    logic [31:0] qout;

    int n_pass, n_total;
    int cyc;
    int nwr, ndone, done_cyc, last_acc, stall_bad, we_bad;
    logic [11:0] wr_addr [128];
    logic [31:0] wr_din [128];
    int          wr_cyc [128];
    logic [3:0]  prev_acc;

    // 0: FS=8 BA=0, 1: FS=6, 2: FS=288, 3: FS=8 BA=16
    fc_input_packer #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .FRAME_SIZE(8), .BASE_ADDR(0)) dut0 (
        .clk(clk), .reset(reset), .i_run(i_run_v[0]), .in_valid(in_valid),
        .in_ready(in_ready_v[0]), .in_data(in_data), .ce_output(ce_v[0]), .we_output(we_v[0]),
        .addr_output(addr_v[0]), .din_output(din_v[0]), .qout_output(qout), .busy(busy_v[0]),
        .load_done(done_v[0]));
    fc_input_packer #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .FRAME_SIZE(6), .BASE_ADDR(0)) dut1 (
        .clk(clk), .reset(reset), .i_run(i_run_v[1]), .in_valid(in_valid),
        .in_ready(in_ready_v[1]), .in_data(in_data), .ce_output(ce_v[1]), .we_output(we_v[1]),
        .addr_output(addr_v[1]), .din_output(din_v[1]), .qout_output(qout), .busy(busy_v[1]),
        .load_done(done_v[1]));
    fc_input_packer #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .FRAME_SIZE(288), .BASE_ADDR(0)) dut2 (
        .clk(clk), .reset(reset), .i_run(i_run_v[2]), .in_valid(in_valid),
        .in_ready(in_ready_v[2]), .in_data(in_data), .ce_output(ce_v[2]), .we_output(we_v[2]),
        .addr_output(addr_v[2]), .din_output(din_v[2]), .qout_output(qout), .busy(busy_v[2]),
        .load_done(done_v[2]));
    fc_input_packer #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .FRAME_SIZE(8), .BASE_ADDR(16)) dut3 (
        .clk(clk), .reset(reset), .i_run(i_run_v[3]), .in_valid(in_valid),
        .in_ready(in_ready_v[3]), .in_data(in_data), .ce_output(ce_v[3]), .we_output(we_v[3]),
        .addr_output(addr_v[3]), .din_output(din_v[3]), .qout_output(qout), .busy(busy_v[3]),
        .load_done(done_v[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Write/done logger, sampled mid-cycle.
    initial begin
        prev_acc = '0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                if (ce_v[d] !== we_v[d]) we_bad++;
                if (ce_v[d] === 1'b1) begin
                    if (!prev_acc[d]) stall_bad++;
                    if (nwr < 128) begin
                        wr_addr[nwr] = addr_v[d];
                        wr_din[nwr]  = din_v[d];
                        wr_cyc[nwr]  = cyc;
                    end
                    nwr++;
                end
                if (done_v[d] === 1'b1) begin
                    ndone++;
                    done_cyc = cyc;
                end
                prev_acc[d] = in_valid && in_ready_v[d];
                if (prev_acc[d]) last_acc = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        nwr = 0;
        ndone = 0;
        stall_bad = 0;
        we_bad = 0;
    endtask

    task automatic start(input int d);
        i_run_v[d] = 1'b1;
        tick();
        i_run_v = '0;
    endtask

    task automatic send(input int d, input logic [7:0] b, input int gaps);
        in_valid = 1'b0;
        repeat (gaps) tick();
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 20 && in_ready_v[d] !== 1'b1; k++) tick();
        chk("ready_wait", in_ready_v[d], 1'b1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic [11:0] a0, input logic [31:0] d0,
                               input logic [11:0] a1, input logic [31:0] d1);
        chk({tag, "_nwr"}, nwr, 2);
        chk({tag, "_addr0"}, wr_addr[0], a0);
        chk({tag, "_din0"}, wr_din[0], d0);
        chk({tag, "_addr1"}, wr_addr[1], a1);
        chk({tag, "_din1"}, wr_din[1], d1);
        chk({tag, "_wr1_time"}, wr_cyc[1], last_acc + 1);
        chk({tag, "_ndone"}, ndone, 1);
        chk({tag, "_done_time"}, done_cyc, last_acc + 2);
        chk({tag, "_we_eq_ce"}, we_bad, 0);
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        clr();
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        i_run_v = '0;
        qout = 32'hdead_beef;
        tick();
        tick();
        chk("reset_ctrl", {in_ready_v[0], ce_v[0], we_v[0], busy_v[0], done_v[0]}, 5'b0);
        chk("reset_addr", addr_v[0], 12'h0);
        chk("reset_din", din_v[0], 32'h0);
        reset = 1'b0;
        tick();

        // Back-to-back frame of 8 bytes.
        clr();
        start(0);
        chk("t1_busy_start", {busy_v[0], in_ready_v[0]}, 2'b11);
        for (int i = 1; i <= 8; i++) send(0, 8'(i), 0);
        chk("t1_last_cycle", {in_ready_v[0], busy_v[0], ce_v[0], done_v[0]}, 4'b0110);
        tick();
        chk("t1_done_cycle", {busy_v[0], ce_v[0], done_v[0]}, 3'b101);
        tick();
        chk("t1_idle", {busy_v[0], done_v[0], in_ready_v[0]}, 3'b000);
        tick();
        check_frame("t1", 12'd0, 32'h0102_0304, 12'd1, 32'h0506_0708);

        // Partial last word.
        clr();
        start(1);
        send(1, 8'hAA, 0);
        send(1, 8'hBB, 0);
        send(1, 8'hCC, 0);
        send(1, 8'hDD, 0);
        send(1, 8'hEE, 0);
        send(1, 8'hFF, 0);
        repeat (4) tick();
        check_frame("t2", 12'd0, 32'hAABB_CCDD, 12'd1, 32'hEEFF_0000);

        // Stalls between bytes.
        clr();
        start(0);
        send(0, 8'h01, 0);
        send(0, 8'h02, 2);
        send(0, 8'h03, 1);
        send(0, 8'h04, 0);
        send(0, 8'h05, 3);
        send(0, 8'h06, 1);
        send(0, 8'h07, 2);
        send(0, 8'h08, 1);
        repeat (4) tick();
        check_frame("t3", 12'd0, 32'h0102_0304, 12'd1, 32'h0506_0708);
        chk("t3_stall_writes", stall_bad, 0);

        // Mid-frame i_run ignored, BASE_ADDR=16, then a second frame.
        clr();
        start(3);
        for (int i = 1; i <= 4; i++) send(3, 8'(8'h40 + i), 0);
        i_run_v[3] = 1'b1;
        send(3, 8'h45, 0);
        i_run_v[3] = 1'b0;
        for (int i = 6; i <= 8; i++) send(3, 8'(8'h40 + i), 1);
        repeat (4) tick();
        check_frame("t4a", 12'd16, 32'h4142_4344, 12'd17, 32'h4546_4748);
        chk("t4_no_restart", {busy_v[3], in_ready_v[3]}, 2'b00);
        clr();
        start(3);
        for (int i = 1; i <= 8; i++) send(3, 8'(8'h10 + i), 0);
        repeat (4) tick();
        check_frame("t4b", 12'd16, 32'h1112_1314, 12'd17, 32'h1516_1718);

        // Reset after 5 of 8 bytes.
        clr();
        start(0);
        for (int i = 1; i <= 5; i++) send(0, 8'(8'h20 + i), 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_after_reset", {in_ready_v[0], ce_v[0], busy_v[0], done_v[0]}, 4'b0);
        repeat (3) tick();
        chk("t5_nwr", nwr, 1);
        chk("t5_addr0", wr_addr[0], 12'd0);
        chk("t5_din0", wr_din[0], 32'h2122_2324);
        chk("t5_ndone", ndone, 0);
        clr();
        start(0);
        for (int i = 1; i <= 8; i++) send(0, 8'(8'h30 + i), 0);
        repeat (4) tick();
        check_frame("t5_fresh", 12'd0, 32'h3132_3334, 12'd1, 32'h3536_3738);

        // Full 288-byte frame.
        clr();
        start(2);
        for (int i = 0; i < 288; i++) send(2, 8'(i), 0);
        repeat (4) tick();
        chk("t6_nwr", nwr, 72);
        for (int k = 0; k < 72; k++) begin
            chk("t6_addr", wr_addr[k], 12'(k));
            chk("t6_din", wr_din[k], {8'(4 * k), 8'(4 * k + 1), 8'(4 * k + 2), 8'(4 * k + 3)});
        end
        chk("t6_ndone", ndone, 1);
        chk("t6_done_time", done_cyc, last_acc + 2);
        chk("t6_stall_writes", stall_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
